// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
//   Turns each byte accepted on the tx_start/tx_data handshake into an
//   asynchronous serial frame. The frame is a start bit, then DBIT data bits
//   LSB first, then an optional parity bit, then the stop period. Bit timing
//   comes from an external 16x-oversampling baud tick.
//
// Parameters
//   DBIT       data bits per frame (5..8); tx_data bits above DBIT-1 are ignored
//   SB_TICK    s_tick count of the stop period (16 = 1, 24 = 1.5, 32 = 2 stop bits)
//   PARITY_EN  1 inserts a parity bit after the data bits
//   PARITY_ODD 0 = even parity, 1 = odd parity
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous reset, active low
//   s_tick       one-clk pulse at 16x baud rate
//   tx_start     one-clk send request, honoured only while idle
//   tx_data      byte to send, captured on the accepted tx_start cycle
//   tx_done_tick one-clk pulse on the edge that completes the stop period
//   tx_busy      high from acceptance until the frame completes
//   tx           serial line, idle high, straight from a flop
module uart_tx_serializer #(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_tick,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_done_tick,
  output logic       tx_busy,
  output logic       tx
);

  localparam int TW = ($clog2(SB_TICK) < 4) ? 4 : $clog2(SB_TICK);
  localparam logic [TW-1:0] TICK_LAST = TW'(15);
  localparam logic [TW-1:0] STOP_LAST = TW'(SB_TICK - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(DBIT - 1);
  localparam logic [7:0]    DMASK     = 8'hFF >> (8 - DBIT);
  localparam logic          ODD       = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_q, par_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // tx_d is the line level for the state being entered. This keeps tx a pure
  // flop output with no decode glitches.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (tx_start) begin
          // Parity is fixed at capture, so later tx_data changes cannot affect it.
          shreg_d = tx_data & DMASK;
          par_d   = (^(tx_data & DMASK)) ^ ODD;
          tick_d  = '0;
          bit_d   = '0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (s_tick) begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            bit_d   = '0;
            tx_d    = shreg_q[0];
            state_d = DATA;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            shreg_d = shreg_q >> 1;
            bit_d   = bit_q + 3'd1;
            if (bit_q == BIT_LAST) begin
              if (PARITY_EN != 0) begin
                tx_d    = par_q;
                state_d = PARITY;
              end else begin
                tx_d    = 1'b1;
                state_d = STOP;
              end
            end else begin
              tx_d = shreg_q[1];
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      PARITY: begin
        if (s_tick) begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (tick_q == STOP_LAST) begin
            tick_d  = '0;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign tx           = tx_q;
  assign tx_busy      = busy_q;
  assign tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer. Five instances with different frame
// parameters share one stimulus stream. A frame-level model decides which
// tx_start requests each instance accepts. Each accepted byte is queued per
// instance. A monitor watches each serial line, pops the byte when the start
// bit appears, and compares the line tick by tick against the frame expected
// for that byte.
module tb_uart_tx_serializer;

  localparam int NC = 5;
  localparam int C_DBIT [NC] = '{8, 8, 8, 8, 5};
  localparam int C_SB   [NC] = '{16, 16, 16, 32, 24};
  localparam int C_PE   [NC] = '{0, 1, 1, 0, 1};
  localparam int C_PO   [NC] = '{0, 0, 1, 0, 1};

  logic       clk = 1'b0;
  logic       reset;
  logic       s_tick;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_w   [NC];
  logic       busy_w [NC];
  logic       done_w [NC];

  always #5 clk = ~clk;

  uart_tx_serializer #(.DBIT(8), .SB_TICK(16), .PARITY_EN(0), .PARITY_ODD(0)) u0 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start), .tx_data(tx_data),
    .tx_done_tick(done_w[0]), .tx_busy(busy_w[0]), .tx(tx_w[0]));
  uart_tx_serializer #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(0)) u1 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start), .tx_data(tx_data),
    .tx_done_tick(done_w[1]), .tx_busy(busy_w[1]), .tx(tx_w[1]));
  uart_tx_serializer #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(1)) u2 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start), .tx_data(tx_data),
    .tx_done_tick(done_w[2]), .tx_busy(busy_w[2]), .tx(tx_w[2]));
  uart_tx_serializer #(.DBIT(8), .SB_TICK(32), .PARITY_EN(0), .PARITY_ODD(0)) u3 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start), .tx_data(tx_data),
    .tx_done_tick(done_w[3]), .tx_busy(busy_w[3]), .tx(tx_w[3]));
  uart_tx_serializer #(.DBIT(5), .SB_TICK(24), .PARITY_EN(1), .PARITY_ODD(1)) u4 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start), .tx_data(tx_data),
    .tx_done_tick(done_w[4]), .tx_busy(busy_w[4]), .tx(tx_w[4]));

  // scoreboard: bytes each instance has accepted but not yet started
  logic [7:0] expq [NC][$];

  // stimulus-side model: ticks left in the frame now on the line (0 = idle)
  int  rem [NC];
  int  acc [NC];
  int  tmode;
  int  tper;
  int  tph;
  bit  stim_done    = 1'b0;
  bit  stim_timeout = 1'b0;

  // monitor-side state
  bit         in_f [NC];
  int         cnt  [NC];
  logic [7:0] cur  [NC];
  int         errors = 0;
  int         checks = 0;

  function automatic int ft(input int c);
    return 16 * (1 + C_DBIT[c] + C_PE[c]) + C_SB[c];
  endfunction

  // Line level expected k ticks into the frame carrying byte d.
  function automatic logic exp_line(input int c, input logic [7:0] d, input int k);
    int r;
    int ones;
    r = k / 16;
    if (r == 0) return 1'b0;
    if (r - 1 < C_DBIT[c]) return d[r-1];
    if (C_PE[c] != 0 && r - 1 == C_DBIT[c]) begin
      ones = 0;
      for (int i = 0; i < C_DBIT[c]; i++) ones += int'(d[i]);
      return ((ones % 2) == 1) ^ (C_PO[c] != 0);
    end
    return 1'b1;
  endfunction

  function automatic bit all_idle();
    for (int c = 0; c < NC; c++) if (rem[c] != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk(input string nm, input int c, input logic act, input logic expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s cfg%0d t=%0t got=%b expected=%b", nm, c, $time, act, expv);
    end
  endtask

  // One clock of stimulus, driven on the falling edge, followed by the model
  // update for the coming rising edge.
  task automatic cyc(input logic go, input logic [7:0] d);
    logic st;
    @(negedge clk);
    if (tmode == 0) begin
      st  = (tph == tper - 1);
      tph = (tph + 1) % tper;
    end else begin
      st = ($urandom_range(0, 2) == 0);
    end
    s_tick   = st;
    tx_start = go;
    tx_data  = d;
    for (int c = 0; c < NC; c++) begin
      if (rem[c] == 0) begin
        if (go) begin
          rem[c] = ft(c);
          expq[c].push_back(d);
          acc[c]++;
        end
      end else if (st) begin
        rem[c]--;
      end
    end
  endtask

  task automatic idle_wait(input int maxc);
    int n;
    n = 0;
    while (!all_idle() && n < maxc) begin
      cyc(1'b0, 8'($urandom));
      n++;
    end
    if (!all_idle()) stim_timeout = 1'b1;
    repeat (3) cyc(1'b0, 8'($urandom));
  endtask

  initial begin
    int n;
    int a0;
    logic go;
    reset = 1'b0; s_tick = 1'b0; tx_start = 1'b0; tx_data = 8'h00;
    tmode = 0; tper = 4; tph = 0;
    for (int c = 0; c < NC; c++) begin rem[c] = 0; acc[c] = 0; end
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (40) cyc(1'b0, 8'($urandom));

    cyc(1'b1, 8'hA5); idle_wait(4000);
    cyc(1'b1, 8'h07); idle_wait(4000);

    // 0x11, a request mid-frame, one in cfg0's done cycle, one just after
    cyc(1'b1, 8'h11);
    repeat (100) cyc(1'b0, 8'($urandom));
    cyc(1'b1, 8'h3C);
    n = 0; go = 1'b0;
    while (!go && n < 4000) begin
      go = (rem[0] == 1 && tph == tper - 1);
      cyc(go, go ? 8'h3C : 8'($urandom));
      n++;
    end
    if (!go) stim_timeout = 1'b1;
    cyc(1'b1, 8'h5A);
    idle_wait(4000);

    // reset during data bit 3 of 0x00 on cfg0
    cyc(1'b1, 8'h00);
    n = 0;
    while (ft(0) - rem[0] != 70 && n < 2000) begin cyc(1'b0, 8'($urandom)); n++; end
    if (ft(0) - rem[0] != 70) stim_timeout = 1'b1;
    @(negedge clk);
    #3 reset = 1'b0;
    for (int c = 0; c < NC; c++) begin rem[c] = 0; expq[c].delete(); end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (60) cyc(1'b0, 8'($urandom));

    // back-to-back 0xFF then 0x00 with tx_start held high (cfg3 = 2 stop bits)
    a0 = acc[3]; n = 0;
    while (acc[3] < a0 + 2 && n < 4000) begin
      cyc(1'b1, (acc[3] == a0) ? 8'hFF : 8'h00);
      n++;
    end
    if (acc[3] < a0 + 2) stim_timeout = 1'b1;
    idle_wait(4000);

    // s_tick on every clock, sparse random requests
    tper = 1; tph = 0;
    repeat (3000) cyc($urandom_range(0, 39) == 0, 8'($urandom));
    idle_wait(4000);

    // irregular s_tick spacing, random requests
    tmode = 1;
    repeat (8000) cyc($urandom_range(0, 59) == 0, 8'($urandom));
    idle_wait(8000);
    repeat (20) cyc(1'b0, 8'($urandom));
    stim_done = 1'b1;
  end

  initial begin
    int ncyc;
    ncyc = 0;
    for (int c = 0; c < NC; c++) begin in_f[c] = 1'b0; cnt[c] = 0; cur[c] = 8'h00; end
    forever begin
      @(posedge clk or negedge reset);
      #1;
      ncyc++;
      if (!reset) begin
        for (int c = 0; c < NC; c++) begin
          chk("rst_tx", c, tx_w[c], 1'b1);
          chk("rst_busy", c, busy_w[c], 1'b0);
          chk("rst_done", c, done_w[c], 1'b0);
          in_f[c] = 1'b0;
        end
      end else begin
        for (int c = 0; c < NC; c++) begin
          if (in_f[c]) begin
            if (s_tick) cnt[c]++;
            if (cnt[c] == ft(c)) begin
              chk("done_pulse", c, done_w[c], 1'b1);
              chk("busy_end", c, busy_w[c], 1'b0);
              chk("stop_tx", c, tx_w[c], 1'b1);
              in_f[c] = 1'b0;
            end else begin
              chk("tx_bit", c, tx_w[c], exp_line(c, cur[c], cnt[c]));
              chk("busy_mid", c, busy_w[c], 1'b1);
              chk("done_mid", c, done_w[c], 1'b0);
            end
          end else if (expq[c].size() != 0) begin
            chk("start_edge", c, tx_w[c], 1'b0);
            chk("busy_start", c, busy_w[c], 1'b1);
            chk("done_start", c, done_w[c], 1'b0);
            cur[c]  = expq[c].pop_front();
            cnt[c]  = 0;
            in_f[c] = 1'b1;
          end else begin
            chk("idle_tx", c, tx_w[c], 1'b1);
            chk("idle_busy", c, busy_w[c], 1'b0);
            chk("idle_done", c, done_w[c], 1'b0);
          end
        end
      end
      if (stim_done || ncyc > 60000) begin
        if (!stim_done) begin
          checks++;
          errors++;
          $display("FAIL watchdog cycles=%0d stimulus not finished", ncyc);
        end
        for (int c = 0; c < NC; c++) begin
          chk("drain_q", c, expq[c].size() == 0, 1'b1);
          chk("drain_frame", c, in_f[c], 1'b0);
        end
        chk("stim_timeout", 0, stim_timeout, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
    end
  end

endmodule
